// File: rtl/qsgmii_arb_pkg.sv
// Shared types and the round-robin pick used by the QSGMII RX frame arbiter.
package qsgmii_arb_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        STREAM  = 2'd2,
        DISCARD = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        start;
        logic        last;
        logic        drop;
        logic [1:0]  lane;
    } lane_beat_t;

    // Returns {found, lane}: first requesting lane at or after ptr, wrapping.
    // The loop runs backwards so the lane closest to ptr is written last and wins.
    function automatic logic [2:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                           input logic [1:0]           ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/eth_skid_buffer.sv
// Two-entry output stage with registered outputs and an occupancy count.
// Handshake: a beat moves on a side exactly in the cycle where valid && ready
// are both high; valid never depends on ready, and the offered beat is held
// stable while valid && !ready.
module eth_skid_buffer
    import qsgmii_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  lane_beat_t in_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output lane_beat_t out_beat,
    output logic [1:0] occupancy
);

    lane_beat_t main_q, main_d, spare_q, spare_d;
    logic       main_v_q, main_v_d, spare_v_q, spare_v_d;
    logic       fire, push;

    // Accept while the spare slot is free, or when full but draining this cycle.
    always_comb begin
        main_d    = main_q;
        main_v_d  = main_v_q;
        spare_d   = spare_q;
        spare_v_d = spare_v_q;
        fire      = main_v_q && out_ready;
        in_ready  = !spare_v_q || out_ready;
        push      = in_valid && in_ready;
        if (fire) begin
            if (spare_v_q) begin
                main_d    = spare_q;
                spare_v_d = push;
                if (push) begin
                    spare_d = in_beat;
                end
            end else begin
                main_v_d = push;
                if (push) begin
                    main_d = in_beat;
                end
            end
        end else if (push) begin
            if (!main_v_q) begin
                main_v_d = 1'b1;
                main_d   = in_beat;
            end else begin
                spare_v_d = 1'b1;
                spare_d   = in_beat;
            end
        end
    end

    // Storage registers; reset empties both slots and zeroes the output beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q    <= '0;
            main_v_q  <= 1'b0;
            spare_q   <= '0;
            spare_v_q <= 1'b0;
        end else begin
            main_q    <= main_d;
            main_v_q  <= main_v_d;
            spare_q   <= spare_d;
            spare_v_q <= spare_v_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_beat  = main_q;
    assign occupancy = {1'b0, main_v_q} + {1'b0, spare_v_q};

endmodule

// File: rtl/qsgmii_rx_frame_arbiter.sv
// Frame-atomic round-robin arbiter: drains one committed frame at a time from
// the four lane FIFOs onto a single 32-bit stream, tagging each beat with its
// lane and truncating frames longer than MAX_FRAME_WORDS.
module qsgmii_rx_frame_arbiter
    import qsgmii_arb_pkg::*;
#(
    parameter int MAX_FRAME_WORDS = 384,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_LANES-1:0]           lane_frame_ready,
    output logic [NUM_LANES-1:0]           lane_rd_en,
    input  logic [NUM_LANES*32-1:0]        lane_rd_data,
    input  logic [NUM_LANES*3-1:0]         lane_rd_bytes,
    input  logic [NUM_LANES-1:0]           lane_rd_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_start,
    output logic [31:0]                    out_data,
    output logic [2:0]                     out_bytes_valid,
    output logic                           out_last,
    output logic                           out_drop,
    output logic [1:0]                     out_lane,
    output logic [NUM_LANES*CNT_WIDTH-1:0] drop_count,
    output arb_state_t                     dbg_state,
    output logic [1:0]                     dbg_rr_ptr
);

    localparam int              WCW      = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [WCW-1:0]  LAST_IDX = WCW'(MAX_FRAME_WORDS - 1);

    arb_state_t           state_q, state_d;
    logic [1:0]           cur_lane_q, cur_lane_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [WCW-1:0]       word_cnt_q, word_cnt_d;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q [NUM_LANES];
    logic [CNT_WIDTH-1:0] drop_cnt_d [NUM_LANES];

    logic       rd_en;
    logic       push_valid, push_ready;
    lane_beat_t push_beat, skid_beat;
    logic [1:0] skid_occ;
    logic       skid_out_valid, out_fire, credit_ok;
    logic [2:0] pick;
    logic [31:0] ret_data;
    logic [2:0]  ret_bytes;
    logic        ret_last;
    logic        ret_is_last;

    assign pick      = rr_pick(lane_frame_ready, rr_ptr_q);
    assign ret_data  = lane_rd_data[{cur_lane_q, 5'd0} +: 32];
    assign ret_bytes = lane_rd_bytes[int'(cur_lane_q) * 3 +: 3];
    assign ret_last  = lane_rd_last[cur_lane_q];
    // The returning word is only meaningful the cycle after a pop.
    assign ret_is_last = inflight_q && ret_last;

    // A beat leaving the skid this cycle frees a slot for the word popped now,
    // which is what sustains one word per cycle with occupancy + in-flight < 2.
    assign out_fire  = skid_out_valid && out_ready;
    assign credit_ok = push_ready &&
                       (({1'b0, skid_occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, out_fire}));

    // Next-state, pop strobe and skid push for the grant/stream/discard sequence.
    always_comb begin
        state_d    = state_q;
        cur_lane_d = cur_lane_q;
        rr_ptr_d   = rr_ptr_q;
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rd_en      = 1'b0;
        push_valid = 1'b0;
        push_beat  = '0;
        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    cur_lane_d = pick[1:0];
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                word_cnt_d = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                // Never pop in the cycle the frame's last word comes back:
                // that pop would steal the first word of the next frame.
                rd_en = credit_ok && !ret_is_last;
                if (inflight_q) begin
                    push_valid      = 1'b1;
                    push_beat.data  = ret_data;
                    push_beat.bytes = ret_bytes;
                    push_beat.start = (word_cnt_q == '0);
                    push_beat.last  = ret_last;
                    push_beat.lane  = cur_lane_q;
                    word_cnt_d      = word_cnt_q + 1'b1;
                    if (ret_last) begin
                        rr_ptr_d = cur_lane_q + 2'd1;
                        state_d  = IDLE;
                    end else if (word_cnt_q == LAST_IDX) begin
                        push_beat.last = 1'b1;
                        push_beat.drop = 1'b1;
                        if (drop_cnt_q[cur_lane_q] != '1) begin
                            drop_cnt_d[cur_lane_q] = drop_cnt_q[cur_lane_q] + 1'b1;
                        end
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                rd_en = !ret_is_last;
                if (ret_is_last) begin
                    rr_ptr_d = cur_lane_q + 2'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d = rd_en;
    end

    // Arbiter state registers; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_lane_q <= 2'd0;
            rr_ptr_q   <= 2'd0;
            word_cnt_q <= '0;
            inflight_q <= 1'b0;
            for (int g = 0; g < NUM_LANES; g++) begin
                drop_cnt_q[g] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cur_lane_q <= cur_lane_d;
            rr_ptr_q   <= rr_ptr_d;
            word_cnt_q <= word_cnt_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    eth_skid_buffer u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_valid),
        .in_ready  (push_ready),
        .in_beat   (push_beat),
        .out_valid (skid_out_valid),
        .out_ready (out_ready),
        .out_beat  (skid_beat),
        .occupancy (skid_occ)
    );

    // Flatten the per-lane drop counters onto the output bus.
    always_comb begin
        drop_count = '0;
        for (int g = 0; g < NUM_LANES; g++) begin
            drop_count[g*CNT_WIDTH +: CNT_WIDTH] = drop_cnt_q[g];
        end
    end

    assign lane_rd_en      = rd_en ? ({{(NUM_LANES-1){1'b0}}, 1'b1} << cur_lane_q) : '0;
    assign out_valid       = skid_out_valid;
    assign out_start       = skid_beat.start;
    assign out_data        = skid_beat.data;
    assign out_bytes_valid = skid_beat.bytes;
    assign out_last        = skid_beat.last;
    assign out_drop        = skid_beat.drop;
    assign out_lane        = skid_beat.lane;
    assign dbg_state       = state_q;
    assign dbg_rr_ptr      = rr_ptr_q;

endmodule
